// File: rtl/stream_win_count_if.sv
// stream_win_count_if: stream and result handshake bundle for stream_win_count.
//   in_valid  - stream bit on 'in' is valid this cycle
//   in        - stream bit from the upstream kernel
//   res       - ones count of the last completed window (WLOG+1 bits)
//   res_valid - 'res' holds an unconsumed result
//   res_ready - consumer accepts 'res'
// master: the environment side (drives stream, consumes result).
// slave:  the counter side.
interface stream_win_count_if #(
    parameter int unsigned WLOG = 8
);
    logic          in_valid;
    logic          in;
    logic [WLOG:0] res;
    logic          res_valid;
    logic          res_ready;

    modport master (
        output in_valid,
        output in,
        output res_ready,
        input  res,
        input  res_valid
    );

    modport slave (
        input  in_valid,
        input  in,
        input  res_ready,
        output res,
        output res_valid
    );
endinterface

// File: rtl/stream_win_count.sv
// stream_win_count: windowed unary-to-binary converter. Counts the 1s in a window of
// 2^WLOG valid stream bits and presents the count behind a registered valid/ready handshake.
//
// Parameters:
//   WLOG - log2 of the window length in stream bits
//   SKIP - warm-up bits discarded after start (1..65535), used only with warm-up
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous reset, active high
//   start - single-cycle run start, honoured only in IDLE
//   cont  - continuous mode, sampled at each window completion
//   busy  - FSM not in IDLE
//   ovf   - sticky: a completed result was dropped because the previous one was unconsumed
//   bus   - stream input and result handshake (stream_win_count_if.slave)
// Configuration:
//   STREAM_WIN_COUNT_WARMUP_EN - when defined, builds the WARM state and a 16-bit skip
//   counter that discards the first SKIP valid bits after start.
module stream_win_count #(
    parameter int unsigned WLOG = 8,
    parameter int unsigned SKIP = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cont,
    output logic               busy,
    output logic               ovf,
    stream_win_count_if.slave  bus
);

    if (SKIP < 1 || SKIP > 65535) begin : g_skip_range
        $error("stream_win_count: SKIP out of range 1..65535");
    end

`ifdef STREAM_WIN_COUNT_WARMUP_EN
    typedef enum logic [1:0] {StIdle, StWarm, StAcc} state_e;
`else
    typedef enum logic [1:0] {StIdle, StAcc} state_e;
`endif

    state_e          state_q, state_d;
    logic [WLOG-1:0] bit_cnt_q, bit_cnt_d;
    logic [WLOG:0]   ones_q, ones_d;
    logic [WLOG:0]   res_q, res_d;
    logic            res_valid_q, res_valid_d;
    logic            ovf_q, ovf_d;
    logic [WLOG:0]   win_count;
    logic            win_done;
`ifdef STREAM_WIN_COUNT_WARMUP_EN
    localparam logic [15:0] SkipLast = 16'(SKIP - 1);
    logic [15:0]     skip_q, skip_d;
`endif

    // Count including the bit sampled this cycle; only meaningful on completion.
    assign win_count = ones_q + {{WLOG{1'b0}}, bus.in};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ones_d      = ones_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        ovf_d       = ovf_q;
        win_done    = 1'b0;
`ifdef STREAM_WIN_COUNT_WARMUP_EN
        skip_d      = skip_q;
`endif

        case (state_q)
            StIdle: begin
                if (start) begin
`ifdef STREAM_WIN_COUNT_WARMUP_EN
                    state_d = StWarm;
                    skip_d  = '0;
`else
                    state_d   = StAcc;
                    bit_cnt_d = '0;
                    ones_d    = '0;
`endif
                end
            end
`ifdef STREAM_WIN_COUNT_WARMUP_EN
            StWarm: begin
                if (bus.in_valid) begin
                    if (skip_q == SkipLast) begin
                        state_d   = StAcc;
                        skip_d    = '0;
                        bit_cnt_d = '0;
                        ones_d    = '0;
                    end else begin
                        skip_d = skip_q + 16'd1;
                    end
                end
            end
`endif
            StAcc: begin
                if (bus.in_valid) begin
                    if (&bit_cnt_q) begin
                        win_done  = 1'b1;
                        bit_cnt_d = '0;
                        ones_d    = '0;
                        state_d   = cont ? StAcc : StIdle;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        ones_d    = win_count;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A completion may load only if the slot is free or being drained this same cycle.
        if (win_done) begin
            if (!res_valid_q || bus.res_ready) begin
                res_d       = win_count;
                res_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            ones_q      <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef STREAM_WIN_COUNT_WARMUP_EN
            skip_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_q      <= ones_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            ovf_q       <= ovf_d;
`ifdef STREAM_WIN_COUNT_WARMUP_EN
            skip_q      <= skip_d;
`endif
        end
    end

    assign busy          = (state_q != StIdle);
    assign ovf           = ovf_q;
    assign bus.res       = res_q;
    assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_stream_win_count.sv
// tb_stream_win_count: directed bench for stream_win_count.
// u4: WLOG=4, SKIP=4. u3: WLOG=3, SKIP=2. Expectations adapt to STREAM_WIN_COUNT_WARMUP_EN.
module tb_stream_win_count;

    logic clk = 1'b0;
    logic rst;
    logic start4, cont4, busy4, ovf4;
    logic start3, cont3, busy3, ovf3;

    stream_win_count_if #(.WLOG(4)) bus4 ();
    stream_win_count_if #(.WLOG(3)) bus3 ();

    stream_win_count #(.WLOG(4), .SKIP(4)) u4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .cont  (cont4),
        .busy  (busy4),
        .ovf   (ovf4),
        .bus   (bus4)
    );

    stream_win_count #(.WLOG(3), .SKIP(2)) u3 (
        .clk   (clk),
        .rst   (rst),
        .start (start3),
        .cont  (cont3),
        .busy  (busy3),
        .ovf   (ovf3),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

`ifdef STREAM_WIN_COUNT_WARMUP_EN
    localparam int Warm4 = 4;
    localparam int Warm3 = 2;
`else
    localparam int Warm4 = 0;
    localparam int Warm3 = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] pat;
        int          exp;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One bit per cycle, LSB first; in_valid drops after the last bit so the
    // following negedge shows the state after the final sampling edge.
    task automatic feed4(input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus4.in_valid = 1'b1;
            bus4.in       = pat[i];
        end
        @(negedge clk);
        bus4.in_valid = 1'b0;
        bus4.in       = 1'b0;
    endtask

    task automatic run4();
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        if (Warm4 > 0) feed4(32'h0, Warm4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n3;
        tbl[0] = '{16'hFFFF, 16};
        tbl[1] = '{16'h0000, 0};
        tbl[2] = '{16'hAAAA, 8};
        tbl[3] = '{16'h0001, 1};
        tbl[4] = '{16'h8000, 1};
        tbl[5] = '{16'h1234, 5};
        tbl[6] = '{16'hF00F, 8};

        rst = 1'b1;
        start4 = 1'b0; cont4 = 1'b0;
        start3 = 1'b0; cont3 = 1'b0;
        bus4.in_valid = 1'b0; bus4.in = 1'b0; bus4.res_ready = 1'b0;
        bus3.in_valid = 1'b0; bus3.in = 1'b0; bus3.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_busy", int'(busy4), 0);
        chk("rst_valid", int'(bus4.res_valid), 0);
        chk("rst_res", int'(bus4.res), 0);
        chk("rst_ovf", int'(ovf4), 0);
        chk("rst_busy3", int'(busy3), 0);

        // Latency: nothing before the 16th bit, result right after it
        bus4.res_ready = 1'b1;
        run4();
        feed4(32'h7FFF, 15);
        chk("lat_pre_valid", int'(bus4.res_valid), 0);
        chk("lat_pre_busy", int'(busy4), 1);
        feed4(32'h1, 1);
        chk("lat_valid", int'(bus4.res_valid), 1);
        chk("lat_res", int'(bus4.res), 16);
        chk("lat_busy", int'(busy4), 0);
        @(negedge clk);
        chk("lat_pulse_end", int'(bus4.res_valid), 0);

        // Table of single windows
        for (int k = 0; k < 7; k++) begin
            run4();
            feed4({16'h0, tbl[k].pat}, 16);
            chk($sformatf("tbl%0d_valid", k), int'(bus4.res_valid), 1);
            chk($sformatf("tbl%0d_res", k), int'(bus4.res), tbl[k].exp);
            chk($sformatf("tbl%0d_busy", k), int'(busy4), 0);
            @(negedge clk);
            chk($sformatf("tbl%0d_drain", k), int'(bus4.res_valid), 0);
        end

        // Warm-up exclusion: 4 ones then 1,0 repeated
        bus4.res_ready = 1'b0;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        feed4(32'h5555F, 20);
        chk("warm_res", int'(bus4.res), (Warm4 > 0) ? 8 : 10);
        chk("warm_valid", int'(bus4.res_valid), 1);
        @(negedge clk);
        bus4.res_ready = 1'b1;
        @(negedge clk);
        bus4.res_ready = 1'b0;

        // 50% in_valid, zero input, WLOG=3
        n3 = 8 + Warm3;
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int c = 0; c < 2 * n3 - 1; c++) begin
            @(negedge clk);
            if (c == 2 * n3 - 2) chk("half_pre_valid", int'(bus3.res_valid), 0);
            bus3.in_valid = (c % 2 == 0);
        end
        @(negedge clk);
        bus3.in_valid = 1'b0;
        chk("half_valid", int'(bus3.res_valid), 1);
        chk("half_res", int'(bus3.res), 0);
        chk("half_busy", int'(busy3), 0);

        // Continuous, never ready: first held, second dropped
        chk("cont_pre_valid", int'(bus4.res_valid), 0);
        cont4 = 1'b1;
        run4();
        feed4(32'hFFFF, 16);
        chk("cont_w1_res", int'(bus4.res), 16);
        chk("cont_w1_valid", int'(bus4.res_valid), 1);
        chk("cont_w1_busy", int'(busy4), 1);
        chk("cont_w1_ovf", int'(ovf4), 0);
        feed4(32'h00FF, 16);
        chk("cont_w2_ovf", int'(ovf4), 1);
        chk("cont_w2_res", int'(bus4.res), 16);
        feed4(32'h0F0F, 16);
        chk("cont_w3_res", int'(bus4.res), 16);
        chk("cont_w3_valid", int'(bus4.res_valid), 1);

        // Reset mid-ACC after 100 bits in ACC
        feed4(32'hFFFFFFFF, 32);
        feed4(32'hFFFFF, 20);
        chk("mid_busy_pre", int'(busy4), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", int'(busy4), 0);
        chk("mid_valid", int'(bus4.res_valid), 0);
        chk("mid_res", int'(bus4.res), 0);
        chk("mid_ovf", int'(ovf4), 0);
        cont4 = 1'b0;
        bus4.res_ready = 1'b1;
        run4();
        feed4(32'h0F0F, 16);
        chk("fresh_res", int'(bus4.res), 8);
        chk("fresh_valid", int'(bus4.res_valid), 1);
        chk("fresh_busy", int'(busy4), 0);
        @(negedge clk);
        bus4.res_ready = 1'b0;

        // Continuous, ready exactly on second completion
        cont4 = 1'b1;
        run4();
        feed4(32'hFFFF, 16);
        chk("rdy_w1_res", int'(bus4.res), 16);
        feed4(32'h7, 15);
        chk("rdy_w2_pre_res", int'(bus4.res), 16);
        @(negedge clk);
        bus4.in_valid  = 1'b1;
        bus4.in        = 1'b1;
        bus4.res_ready = 1'b1;
        @(negedge clk);
        bus4.in_valid  = 1'b0;
        bus4.in        = 1'b0;
        bus4.res_ready = 1'b0;
        chk("rdy_w2_valid", int'(bus4.res_valid), 1);
        chk("rdy_w2_res", int'(bus4.res), 4);
        chk("rdy_w2_ovf", int'(ovf4), 0);
        chk("rdy_w2_busy", int'(busy4), 1);
        cont4 = 1'b0;
        bus4.res_ready = 1'b1;
        feed4(32'h0, 16);
        chk("rdy_w3_res", int'(bus4.res), 0);
        chk("rdy_w3_valid", int'(bus4.res_valid), 1);
        chk("rdy_w3_busy", int'(busy4), 0);
        chk("rdy_w3_ovf", int'(ovf4), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_win_count.md
# stream_win_count

Windowed unary-to-binary converter placed directly downstream of the square-root bitstream kernel. It counts the 1s in a fixed window of `2^WLOG` valid stream bits and presents the count as a binary result behind a valid/ready handshake. An optional warm-up phase discards the first bits of a run, so the feedback transient of the upstream kernel is kept out of the measurement.

## Interface
- `WLOG`, default 8: log2 of the window length in stream bits. The window is `2^WLOG` bits.
- `SKIP`, default 16: number of warm-up bits discarded after `start`. Used only when `STREAM_WIN_COUNT_WARMUP_EN` is defined. Valid range is 1..65535.

Ports:
- `clk`, input, 1: clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous reset, active high.
- `start`, input, 1: single-cycle pulse that starts a run. Ignored unless the FSM is in IDLE.
- `cont`, input, 1: continuous mode. It is sampled when each window completes.
- `in_valid`, input, 1: the stream bit on `in` is valid this cycle.
- `in`, input, 1: stream bit from the upstream kernel's `out`.
- `busy`, output, 1: high when the FSM is not in IDLE.
- `res`, output, WLOG+1: 1s count of the last completed window, range 0..2^WLOG.
- `res_valid`, output, 1: `res` holds an unconsumed result.
- `res_ready`, input, 1: consumer accepts `res`.
- `ovf`, output, 1: sticky flag; a result was dropped.

## Operation
- FSM states: IDLE, WARM, ACC.
- Reset applies when `rst`=1 at a rising edge, including mid-run. It puts the FSM in IDLE and clears all counters, `res`, `res_valid` and `ovf` to 0.
- **IDLE**
  - When `start`=1, go to WARM if warm-up is compiled in; otherwise go to ACC.
  - Entering ACC clears the bit counter and the ones counter.
- **WARM**
  - The skip counter increments on each `in_valid`=1. The bits are discarded.
  - On the `SKIP`-th valid bit, go to ACC with both ACC counters cleared.
- **ACC**
  - On each `in_valid`=1, the bit counter increments and the ones counter adds `in`.
  - On the `2^WLOG`-th valid bit, the window completes:
    - The result is the ones count including that bit.
    - If `cont`=1, re-enter ACC with the counters cleared and no warm-up. Otherwise go to IDLE.
- Counter widths:
  - Bit counter: WLOG bits; completion is when its value is all-ones and `in_valid`=1.
  - Ones counter: WLOG+1 bits; it cannot overflow.
- Output register, on window completion:
  - If `res_valid`=0, or `res_valid`=1 and `res_ready`=1 in the same cycle: load `res` and hold `res_valid`=1.
  - If `res_valid`=1 and `res_ready`=0: keep the old `res`, drop the new one and set `ovf`=1. `ovf` stays set until `rst`.
- With no completion: `res_valid`=1 and `res_ready`=1 clears `res_valid`. `res` keeps its value.
- Bits with `in_valid`=0 are ignored in every state. `start` outside IDLE is ignored.

## Timing
- `res` and `res_valid` update on the clock edge that samples the last window bit. They are visible in the next cycle, so latency is 1 cycle.
- `busy` rises in the cycle after `start` is sampled and falls in the cycle after the final window completes (`cont`=0).
- Back-to-back: in continuous mode there is no dead cycle between windows. The first bit of the next window may arrive in the cycle right after completion.
- The handshake is registered. `res_ready` has no combinational path to any output.

## Configuration
- Macro `STREAM_WIN_COUNT_WARMUP_EN`.
- Defined: the WARM state and a 16-bit skip counter are built, and the first `SKIP` valid bits after `start` are discarded.
- Undefined: WARM and the skip counter are absent, `SKIP` is unused, and `start` goes directly to ACC.

## Test plan
- Reset mid-ACC: `rst` asserted after 100 bits. Next cycle: `busy`=0, `res_valid`=0, `res`=0, `ovf`=0. A later `start` begins a fresh window.
- WLOG=4, no warm-up, `in`=1 on every valid cycle, `res_ready`=1: `res`=16, with `res_valid` pulsing one cycle after the 16th bit.
- WLOG=4, `SKIP`=4, warm-up defined: 4 ones followed by the pattern 1,0 repeated. Result `res`=8; the first 4 bits are excluded.
- `in_valid` toggling 50% with all-zero `in`, WLOG=3: completion occurs after 8 valid bits (about 16 cycles) with `res`=0.
- `cont`=1, `res_ready`=0, three windows: the first result is held, the second is dropped and `ovf`=1, and `res` still shows the first window's count.
- `cont`=1, `res_ready`=1 on the exact completion cycle of the second window: `res_valid` stays 1, `res` takes the second count and `ovf`=0.
